// File: rtl/toggle_cover_collector.sv
// Purpose: toggle coverage collector; flags each 0->1 and 1->0 edge of every probed bit once per re-arm.
// Latency: a toggle sampled at edge N pulses valid (and bumps covered_cnt) in the cycle after edge N.
// Backpressure: none; valid is a one-cycle pulse and all toggles in a sample are reported together.
module toggle_cover_collector #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [WIDTH-1:0]   sig,
    output logic [2*WIDTH-1:0] valid,
    output logic [CNT_W-1:0]   covered_cnt,
    output logic               all_covered
);

    localparam int NPTS = 2 * WIDTH;
    localparam logic [CNT_W-1:0] NPTS_C = CNT_W'(NPTS);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [NPTS-1:0]  seen_q, seen_d;
    logic [NPTS-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_q, all_d;

    logic [WIDTH-1:0] rise_dat;
    logic [WIDTH-1:0] fall_dat;
    logic [NPTS-1:0]  new_dat;
    logic [CNT_W-1:0] new_cnt;

    // Edge detection against the previous sample, masked by points already covered.
    always_comb begin
        rise_dat = ~prev_q & sig;
        fall_dat = prev_q & ~sig;
        new_dat  = {fall_dat, rise_dat} & ~seen_q;
        new_cnt  = '0;
        for (int i = 0; i < NPTS; i++) begin
            new_cnt = new_cnt + {{(CNT_W-1){1'b0}}, new_dat[i]};
        end
    end

    // Next-state selection: clear re-arms, a disabled cycle drops priming,
    // the first enabled sample only primes, later samples record new coverage.
    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        seen_d   = seen_q;
        valid_d  = '0;
        cnt_d    = cnt_q;
        if (clear) begin
            seen_d   = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (!enable) begin
            primed_d = 1'b0;
        end else if (!primed_q) begin
            prev_d   = sig;
            primed_d = 1'b1;
        end else begin
            prev_d  = sig;
            valid_d = new_dat;
            seen_d  = seen_q | new_dat;
            cnt_d   = cnt_q + new_cnt;
        end
        all_d = (cnt_d == NPTS_C);
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            seen_q   <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
            all_q    <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            seen_q   <= seen_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            all_q    <= all_d;
        end
    end

    assign valid       = valid_q;
    assign covered_cnt = cnt_q;
    assign all_covered = all_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Purpose: randomized and directed bench for toggle_cover_collector against a point-level coverage model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_toggle_cover_collector;

    localparam int W = 32;
    localparam int N = 2 * W;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  sig = '0;
    logic [N-1:0]  valid;
    logic [6:0]    covered_cnt;
    logic          all_covered;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model state: which coverage points have been hit, and the last sample.
    bit           hit [N];
    int           m_hits;
    bit [W-1:0]   m_prev;
    bit           m_primed;
    bit [N-1:0]   m_valid;

    toggle_cover_collector #(.WIDTH(W), .CNT_W(7)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid),
        .covered_cnt (covered_cnt),
        .all_covered (all_covered)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_forget();
        for (int p = 0; p < N; p++) hit[p] = 1'b0;
        m_hits = 0;
    endfunction

    // One clock edge of the model, written per coverage point.
    function automatic void model_edge(input bit rst_n, input bit en, input bit clr, input bit [W-1:0] s);
        m_valid = '0;
        if (!rst_n) begin
            model_forget();
            m_prev   = '0;
            m_primed = 1'b0;
        end else if (clr) begin
            model_forget();
            m_primed = 1'b0;
        end else if (!en) begin
            m_primed = 1'b0;
        end else if (!m_primed) begin
            m_prev   = s;
            m_primed = 1'b1;
        end else begin
            for (int b = 0; b < W; b++) begin
                if (m_prev[b] != s[b]) begin
                    int p;
                    p = s[b] ? b : W + b;
                    if (!hit[p]) begin
                        hit[p]     = 1'b1;
                        m_hits     = m_hits + 1;
                        m_valid[p] = 1'b1;
                    end
                end
            end
            m_prev = s;
        end
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, then compare all outputs.
    task automatic step(input bit rst_n, input bit en, input bit clr, input logic [W-1:0] s, input string tag);
        @(negedge clock);
        reset  = rst_n;
        enable = en;
        clear  = clr;
        sig    = s;
        @(posedge clock);
        model_edge(rst_n, en, clr, s);
        #1;
        check({tag, "_valid"}, 64'(valid), 64'(m_valid));
        check({tag, "_cnt"}, 64'(covered_cnt), 64'(m_hits));
        check({tag, "_all"}, 64'(all_covered), 64'(m_hits == N));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, "rst");
        step(1'b0, 1'b0, 1'b0, '0, "rst");
    endtask

    logic [W-1:0] rs;

    initial begin
        model_forget();
        m_prev   = '0;
        m_primed = 1'b0;
        m_valid  = '0;

        do_reset();
        check("reset_valid", 64'(valid), 64'h0);
        check("reset_cnt", 64'(covered_cnt), 64'd0);

        // Single rise of bit 0 after priming on zero.
        step(1, 1, 0, 32'h0, "r25a");
        step(1, 1, 0, 32'h1, "r25b");
        check("r25_valid", 64'(valid), 64'h1);
        check("r25_cnt", 64'(covered_cnt), 64'd1);
        step(1, 1, 0, 32'h1, "r25c");
        check("r25_one_cycle", 64'(valid), 64'h0);

        // All bits rise, then all fall, then rise again with nothing left to cover.
        do_reset();
        step(1, 1, 0, 32'h0, "r26p");
        step(1, 1, 0, 32'hFFFF_FFFF, "r26a");
        check("r26_rise", 64'(valid), 64'h0000_0000_FFFF_FFFF);
        check("r26_cnt32", 64'(covered_cnt), 64'd32);
        step(1, 1, 0, 32'h0, "r26b");
        check("r26_fall", 64'(valid), 64'hFFFF_FFFF_0000_0000);
        check("r26_cnt64", 64'(covered_cnt), 64'd64);
        check("r26_all", 64'(all_covered), 64'd1);
        step(1, 1, 0, 32'hFFFF_FFFF, "r26c");
        check("r26_quiet", 64'(valid), 64'h0);

        // Clear together with a toggle discards it; coverage restarts after re-prime.
        step(1, 1, 1, 32'h0, "r28a");
        check("r28_cnt", 64'(covered_cnt), 64'd0);
        check("r28_all", 64'(all_covered), 64'd0);
        check("r28_valid", 64'(valid), 64'h0);
        step(1, 1, 0, 32'h0, "r28p");
        step(1, 1, 0, 32'h4, "r28b");
        check("r28_again", 64'(valid), 64'h4);

        // Prime only, then an enable gap hides the 0x5 -> 0xA change.
        do_reset();
        step(1, 1, 0, 32'h5, "r27a");
        check("r27_prime", 64'(valid), 64'h0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 32'hA, "r27g");
        step(1, 1, 0, 32'hA, "r27b");
        check("r27_reprime", 64'(valid), 64'h0);
        check("r27_cnt", 64'(covered_cnt), 64'd0);

        // Repeated toggles of bit 3 each cover once.
        do_reset();
        step(1, 1, 0, 32'h0, "r29p");
        step(1, 1, 0, 32'h8, "r29a");
        check("r29_rise", 64'(valid), 64'h8);
        step(1, 1, 0, 32'h0, "r29b");
        check("r29_fall", 64'(valid), 64'h8 << 32);
        step(1, 1, 0, 32'h8, "r29c");
        check("r29_repeat", 64'(valid), 64'h0);
        check("r29_cnt", 64'(covered_cnt), 64'd2);

        // Reset coinciding with a rise drops it.
        do_reset();
        step(1, 1, 0, 32'h0, "r30p");
        step(0, 1, 0, 32'h1, "r30a");
        check("r30_valid", 64'(valid), 64'h0);
        check("r30_cnt", 64'(covered_cnt), 64'd0);
        step(1, 1, 0, 32'h1, "r30b");
        check("r30_after", 64'(valid), 64'h0);

        // Randomized traffic: sparse bit flips, occasional gaps, clears and resets.
        do_reset();
        rs = '0;
        for (int c = 0; c < 3000; c++) begin
            bit en_r, clr_r, rst_r;
            rs    = rs ^ ($urandom() & $urandom() & $urandom());
            en_r  = ($urandom_range(0, 7) != 0);
            clr_r = ($urandom_range(0, 399) == 0);
            rst_r = ($urandom_range(0, 799) != 0);
            step(rst_r, en_r, clr_r, rs, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
